// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the staged reset release sequencer.
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        WAIT,
        UP,
        FAULT
    } seqState_t;

    localparam int MAX_STAGES = 8;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/reset_sequencer_timer.sv
// Clearable up-counter with terminal-count compare; saturates at the limit.
module reset_sequencer_timer #(
    parameter int WIDTH = 16
) (
    input  logic             iClk100,
    input  logic             iRst_n,
    input  logic             iClear,
    input  logic             iEnable,
    input  logic [WIDTH-1:0] iLimit,
    output logic             oDone
);

    logic [WIDTH-1:0] countReg;

    always_ff @(posedge iClk100 or negedge iRst_n) begin
        if (!iRst_n) begin
            countReg <= '0;
        end else if (iClear) begin
            countReg <= '0;
        end else if (iEnable && !oDone) begin
            countReg <= countReg + WIDTH'(1);
        end
    end

    assign oDone = (countReg == iLimit);

endmodule

// File: rtl/reset_sequencer.sv
// Releases downstream reset domains one at a time after a settle gap, waits for
// each ready acknowledge and re-holds everything on a timeout or a dropped ready.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int STAGES         = 4,
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              iClk100,
    input  logic              iRst_n,
    input  logic              iPorDone,
    input  logic              iSoftRst,
    input  logic [STAGES-1:0] iStageRdy,
    output logic [STAGES-1:0] oRst_n,
    output logic              oAllUp,
    output logic              oFault,
    output logic [2:0]        oStage
);

    localparam int MAX_CYCLES = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CW_RAW     = clog2(MAX_CYCLES);
    localparam int CW         = (CW_RAW < 1) ? 1 : CW_RAW;

    localparam logic [CW-1:0] GAP_LIM  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    LAST_IDX = 3'(STAGES - 1);

    seqState_t         stateReg, stateNext;
    logic [STAGES-1:0] rstReg, rstNext;
    logic              allUpReg, allUpNext;
    logic              faultReg, faultNext;
    logic [2:0]        stageReg, stageNext;

    logic              ctrClear;
    logic              ctrEnable;
    logic [CW-1:0]     ctrLimit;
    logic              ctrDone;
    logic [STAGES-1:0] stageSel;
    logic              curRdy;

    // One-hot decode of the stage index, used both to release and to pick its ready.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : gStageSel
            assign stageSel[gi] = (stageReg == 3'(gi));
        end
    endgenerate

    assign curRdy    = |(stageSel & iStageRdy);
    assign ctrEnable = (stateReg == GAP) || (stateReg == WAIT);
    assign ctrLimit  = (stateReg == WAIT) ? TO_LIM : GAP_LIM;

    reset_sequencer_timer #(
        .WIDTH (CW)
    ) uTimer (
        .iClk100 (iClk100),
        .iRst_n  (iRst_n),
        .iClear  (ctrClear),
        .iEnable (ctrEnable),
        .iLimit  (ctrLimit),
        .oDone   (ctrDone)
    );

    always_ff @(posedge iClk100 or negedge iRst_n) begin
        if (!iRst_n) begin
            stateReg <= IDLE;
            rstReg   <= '0;
            allUpReg <= 1'b0;
            faultReg <= 1'b0;
            stageReg <= 3'd0;
        end else begin
            stateReg <= stateNext;
            rstReg   <= rstNext;
            allUpReg <= allUpNext;
            faultReg <= faultNext;
            stageReg <= stageNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        rstNext   = rstReg;
        allUpNext = allUpReg;
        faultNext = faultReg;
        stageNext = stageReg;
        ctrClear  = 1'b1;

        // A latched fault survives POR loss; only soft or hard reset clears it.
        if (iSoftRst || (!iPorDone && stateReg != FAULT)) begin
            stateNext = IDLE;
            rstNext   = '0;
            allUpNext = 1'b0;
            faultNext = 1'b0;
            stageNext = 3'd0;
        end else begin
            case (stateReg)
                IDLE: begin
                    stateNext = GAP;
                end
                GAP: begin
                    if (ctrDone) begin
                        stateNext = WAIT;
                        rstNext   = rstReg | stageSel;
                    end else begin
                        ctrClear = 1'b0;
                    end
                end
                WAIT: begin
                    if (curRdy) begin
                        if (stageReg == LAST_IDX) begin
                            stateNext = UP;
                            allUpNext = 1'b1;
                        end else begin
                            stateNext = GAP;
                            stageNext = stageReg + 3'd1;
                        end
                    end else if (ctrDone) begin
                        stateNext = FAULT;
                        rstNext   = '0;
                        faultNext = 1'b1;
                    end else begin
                        ctrClear = 1'b0;
                    end
                end
                UP: begin
                    if (!(&iStageRdy)) begin
                        stateNext = FAULT;
                        rstNext   = '0;
                        allUpNext = 1'b0;
                        faultNext = 1'b1;
                        // Report the lowest stage whose ready went away.
                        for (int i = STAGES - 1; i >= 0; i--) begin
                            if (!iStageRdy[i]) begin
                                stageNext = 3'(i);
                            end
                        end
                    end
                end
                FAULT: begin
                    stateNext = FAULT;
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    assign oRst_n = rstReg;
    assign oAllUp = allUpReg;
    assign oFault = faultReg;
    assign oStage = stageReg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus queues the expected output changes with their edge
// numbers; a monitor compares each observed output change against the queue.
module tb_reset_sequencer;

    localparam int STAGES = 4;

    logic              iClk100 = 1'b0;
    logic              iRst_n;
    logic              iPorDone;
    logic              iSoftRst;
    logic [STAGES-1:0] iStageRdy;
    logic [STAGES-1:0] oRst_n;
    logic              oAllUp;
    logic              oFault;
    logic [2:0]        oStage;

    reset_sequencer #(
        .STAGES         (STAGES),
        .GAP_CYCLES     (10),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .iClk100   (iClk100),
        .iRst_n    (iRst_n),
        .iPorDone  (iPorDone),
        .iSoftRst  (iSoftRst),
        .iStageRdy (iStageRdy),
        .oRst_n    (oRst_n),
        .oAllUp    (oAllUp),
        .oFault    (oFault),
        .oStage    (oStage)
    );

    always #5 iClk100 = ~iClk100;

    int cyc = 0;
    always @(posedge iClk100) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [8:0]  vec;
        string       name;
    } expEvt_t;

    expEvt_t    expQ[$];
    expEvt_t    ev;
    int         checkCount = 0;
    int         passCount  = 0;
    bit         monOn      = 1'b0;
    logic [8:0] lastVec    = 9'd0;
    logic [8:0] outVec;
    int         t0, t2, t3, t4, t5;

    assign outVec = {oRst_n, oAllUp, oFault, oStage};

    task automatic pushExp(input int c, input logic [3:0] r, input logic up,
                           input logic f, input logic [2:0] s, input string n);
        expQ.push_back('{cyc: c, vec: {r, up, f, s}, name: n});
    endtask

    task automatic doCheck(input string n, input logic [8:0] actVec, input logic [8:0] expVec,
                           input int actCyc, input int expCyc);
        checkCount++;
        if (actVec === expVec && actCyc == expCyc) begin
            passCount++;
            $display("ok   %s: rst_n/allUp/fault/stage=%b at edge %0d", n, actVec, actCyc);
        end else begin
            $display("FAIL %s: got %b at edge %0d, required %b at edge %0d",
                     n, actVec, actCyc, expVec, expCyc);
        end
    endtask

    task automatic atNeg(input int n);
        if (cyc > n) begin
            checkCount++;
            $display("FAIL schedule: at edge %0d, required edge %0d not yet passed", cyc, n);
        end
        while (cyc < n) @(negedge iClk100);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        iRst_n    = 1'b0;
        iPorDone  = 1'b0;
        iSoftRst  = 1'b0;
        iStageRdy = '0;

        fork
            forever begin
                @(negedge iClk100);
                if (monOn && outVec !== lastVec) begin
                    if (expQ.size() == 0) begin
                        checkCount++;
                        $display("FAIL unexpected_change: got %b at edge %0d, required no change (was %b)",
                                 outVec, cyc, lastVec);
                    end else begin
                        ev = expQ.pop_front();
                        doCheck(ev.name, outVec, ev.vec, cyc, ev.cyc);
                    end
                    lastVec = outVec;
                end
            end
        join_none

        atNeg(3);
        iRst_n = 1'b1;
        atNeg(4);
        doCheck("reset_state", outVec, 9'd0, cyc, 4);
        monOn = 1'b1;

        // Nominal release, then a ready drop while all stages are up.
        atNeg(5);
        iPorDone = 1'b1;
        t0 = 6;
        pushExp(t0 + 10, 4'b0001, 1'b0, 1'b0, 3'd0, "nom_rel0");
        pushExp(t0 + 13, 4'b0001, 1'b0, 1'b0, 3'd1, "nom_stage1");
        pushExp(t0 + 23, 4'b0011, 1'b0, 1'b0, 3'd1, "nom_rel1");
        pushExp(t0 + 26, 4'b0011, 1'b0, 1'b0, 3'd2, "nom_stage2");
        pushExp(t0 + 36, 4'b0111, 1'b0, 1'b0, 3'd2, "nom_rel2");
        pushExp(t0 + 39, 4'b0111, 1'b0, 1'b0, 3'd3, "nom_stage3");
        pushExp(t0 + 49, 4'b1111, 1'b0, 1'b0, 3'd3, "nom_rel3");
        pushExp(t0 + 52, 4'b1111, 1'b1, 1'b0, 3'd3, "nom_allup");
        pushExp(t0 + 56, 4'b0000, 1'b0, 1'b1, 3'd1, "up_drop_fault");
        pushExp(t0 + 61, 4'b0000, 1'b0, 1'b0, 3'd0, "soft_clear1");
        atNeg(t0 + 12); iStageRdy[0] = 1'b1;
        atNeg(t0 + 25); iStageRdy[1] = 1'b1;
        atNeg(t0 + 38); iStageRdy[2] = 1'b1;
        atNeg(t0 + 51); iStageRdy[3] = 1'b1;
        atNeg(t0 + 55); iStageRdy[1] = 1'b0;
        atNeg(t0 + 60); iSoftRst = 1'b1; iStageRdy = '0;
        atNeg(t0 + 61); iSoftRst = 1'b0;

        // Ready on the timeout edge for stage 1, then stage 2 times out.
        t2 = t0 + 62;
        pushExp(t2 + 10, 4'b0001, 1'b0, 1'b0, 3'd0, "to_rel0");
        pushExp(t2 + 13, 4'b0001, 1'b0, 1'b0, 3'd1, "to_stage1");
        pushExp(t2 + 23, 4'b0011, 1'b0, 1'b0, 3'd1, "to_rel1");
        pushExp(t2 + 43, 4'b0011, 1'b0, 1'b0, 3'd2, "rdy_on_timeout_edge");
        pushExp(t2 + 53, 4'b0111, 1'b0, 1'b0, 3'd2, "to_rel2");
        pushExp(t2 + 73, 4'b0000, 1'b0, 1'b1, 3'd2, "timeout_fault");
        pushExp(t2 + 81, 4'b0000, 1'b0, 1'b0, 3'd0, "soft_clear2");
        atNeg(t2 + 12); iStageRdy[0] = 1'b1;
        atNeg(t2 + 42); iStageRdy[1] = 1'b1;
        atNeg(t2 + 75); iPorDone = 1'b0;
        atNeg(t2 + 78); iPorDone = 1'b1;
        atNeg(t2 + 80); iSoftRst = 1'b1; iStageRdy = '0;
        atNeg(t2 + 81); iSoftRst = 1'b0;

        // POR loss during the stage 2 gap.
        t3 = t2 + 82;
        pushExp(t3 + 10, 4'b0001, 1'b0, 1'b0, 3'd0, "por_rel0");
        pushExp(t3 + 13, 4'b0001, 1'b0, 1'b0, 3'd1, "por_stage1");
        pushExp(t3 + 23, 4'b0011, 1'b0, 1'b0, 3'd1, "por_rel1");
        pushExp(t3 + 26, 4'b0011, 1'b0, 1'b0, 3'd2, "por_stage2");
        pushExp(t3 + 31, 4'b0000, 1'b0, 1'b0, 3'd0, "por_loss");
        atNeg(t3 + 12); iStageRdy[0] = 1'b1;
        atNeg(t3 + 25); iStageRdy[1] = 1'b1;
        atNeg(t3 + 30); iPorDone = 1'b0; iStageRdy = '0;
        atNeg(t3 + 33); iPorDone = 1'b1;

        // Hard reset pulse between edges while stage 0 waits for ready.
        t4 = t3 + 34;
        pushExp(t4 + 10, 4'b0001, 1'b0, 1'b0, 3'd0, "rerel0");
        atNeg(t4 + 12);
        pushExp(t4 + 13, 4'b0000, 1'b0, 1'b0, 3'd0, "async_seen");
        #2 iRst_n = 1'b0;
        #1 doCheck("async_immediate", outVec, 9'd0, cyc, t4 + 12);
        #1 iRst_n = 1'b1;
        t5 = t4 + 13;
        pushExp(t5 + 10, 4'b0001, 1'b0, 1'b0, 3'd0, "async_restart_rel0");

        atNeg(t5 + 15);
        doCheck("queue_drained", 9'(expQ.size()), 9'd0, cyc, t5 + 15);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Consumes the power-on-reset-done level and releases downstream reset domains one stage at a time in the 100 MHz domain. Each stage gets a fixed settle gap before release and must acknowledge readiness within a timeout. Missing acknowledges raise a fault and re-assert every stage. It sits between the POR delay block and the SDRAM, video and host-interface resets.

## Interface
- STAGES, 4: number of sequenced reset domains, legal 1..8.
- GAP_CYCLES, 1000: settle cycles before each stage release, at least 1.
- TIMEOUT_CYCLES, 50000: maximum cycles to wait for a stage ready, at least 1.

- iClk100  in  1  sole clock. Fixed: one clock.
- iRst_n  in  1  reset. Fixed: asynchronous and active-low.
- iPorDone  in  1  POR-done level, already synchronous to iClk100.
- iSoftRst  in  1  synchronous soft-reset request, level-sensitive.
- iStageRdy  in  STAGES  per-stage ready acknowledge, synchronous.
- oRst_n  out  STAGES  per-stage active-low resets, registered.
- oAllUp  out  1  all stages released and acknowledged, registered.
- oFault  out  1  a stage timed out or dropped ready, registered.
- oStage  out  3  index of the stage currently being sequenced, registered.

## Operation
- States:
  - IDLE: all stages held in reset.
  - GAP: settle counter running.
  - WAIT: current stage released, waiting for its ready.
  - UP: every stage released and acknowledged.
  - FAULT: all stages re-held after a failure.
- iRst_n low:
  - State goes to IDLE, oRst_n all zero, oAllUp=0, oFault=0, oStage=0, counter=0.
  - Applies at any time, mid-sequence included.
- Priority each edge:
  1. iSoftRst.
  2. iPorDone low.
  3. Ready and timeout.
- iSoftRst high in any state:
  - Next state IDLE.
  - oRst_n all 0, oAllUp=0, oFault=0, oStage=0.
- iPorDone low in any state except FAULT:
  - Next state IDLE, with the same outputs as soft reset.
  - In FAULT, iPorDone low is ignored. Only iSoftRst or iRst_n clears FAULT.
- IDLE:
  - Moves to GAP when iPorDone=1 and iSoftRst=0.
  - The counter clears to 0 on this transition.
- GAP:
  - Counter increments each cycle.
  - When the counter equals GAP_CYCLES-1: next state WAIT, oRst_n[oStage] set to 1, counter cleared.
- WAIT:
  - iStageRdy[oStage]=1 and oStage=STAGES-1: next state UP, oAllUp=1.
  - iStageRdy[oStage]=1 and oStage<STAGES-1: oStage increments, next state GAP, counter cleared.
  - Ready low and counter=TIMEOUT_CYCLES-1: next state FAULT.
  - Ready sampled on the same edge as the timeout wins.
- UP:
  - Any iStageRdy bit dropping: next state FAULT.
- FAULT entry:
  - oRst_n all 0, oFault=1, oAllUp=0.
  - oStage holds the failing stage index for debug.
- Released stages stay released while later stages sequence.
- Only the current stage's ready is monitored during WAIT.
- Counter width: clog2(max(GAP_CYCLES, TIMEOUT_CYCLES)). Counter never wraps.

## Timing
- oRst_n[0] rises exactly GAP_CYCLES edges after the edge that first samples iPorDone=1 in IDLE.
- oRst_n[k+1] rises exactly GAP_CYCLES edges after the edge that samples iStageRdy[k]=1.
- oAllUp rises on the same edge that samples the last ready.
- Timeout: FAULT is entered TIMEOUT_CYCLES edges after entering WAIT with ready never sampled high.
- Soft reset, POR loss, drop and fault: reset re-assertion appears one edge after the causing sample.
- Async reset: outputs take reset values immediately, not waiting for a clock edge.

## Structure
- Package reset_sequencer_pkg holds:
  - the state enum typedef (IDLE, GAP, WAIT, UP, FAULT);
  - the maximum stage count constant (8);
  - a clog2 helper for counter width.
- One sub-module, reset_sequencer_timer:
  - clearable up-counter with a terminal-count compare;
  - shared by the GAP and WAIT states.
- The FSM, output registers and stage index live in reset_sequencer.

## Test plan
- Nominal release:
  - Stimulus: STAGES=4, GAP_CYCLES=10, TIMEOUT_CYCLES=20; iPorDone high at cycle 0; each ready driven high 3 cycles after its reset rises.
  - Required: oRst_n[0] rises at cycle 10, [1] at 23, [2] at 36, [3] at 49; oAllUp=1 at cycle 52.
- Timeout:
  - Stimulus: same configuration; stage 2 ready held low.
  - Required: oFault=1 and oRst_n=4'b0000 exactly 20 cycles after oRst_n[2] rises; oStage=2.
  - Then iSoftRst pulsed for 1 cycle: oFault=0 and the sequence restarts from stage 0.
- Ready on the timeout edge:
  - Stimulus: stage 1 ready asserted on cycle 19 of WAIT.
  - Required: no fault; stage 2 sequences normally.
- POR loss mid-sequence:
  - Stimulus: iPorDone dropped while in GAP for stage 2.
  - Required: all oRst_n=0 on the next edge, oFault=0.
  - Then iPorDone returns: re-release starts at stage 0.
- Drop in UP:
  - Stimulus: iStageRdy[1] drops after oAllUp=1.
  - Required: oFault=1, oAllUp=0, all resets asserted on the next edge.
- Async reset:
  - Stimulus: iRst_n pulsed low between edges during WAIT.
  - Required: outputs reset immediately; sequence restarts after deassertion.
